// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings and the error-response state type.
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [1:0] {
      OKAY_ST = 2'd0,
      ERR1    = 2'd1,
      ERR2    = 2'd2
   } err_state_e;

endpackage

// File: rtl/ahb_slave_if_param_if.sv
// AHB-side bus bundle between the bus mux / APB controller and the slave front end.
interface ahb_slave_if_param_if #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_SLV  = 3,
   parameter int ERRCNT_W = 8
);
   logic                Hwrite;
   logic                Hreadyin;
   logic [1:0]          Htrans;
   logic [ADDR_W-1:0]   Haddr;
   logic [DATA_W-1:0]   Hwdata;
   logic [DATA_W-1:0]   prdata;
   logic                apb_ready;

   logic [ADDR_W-1:0]   Haddr1;
   logic [ADDR_W-1:0]   Haddr2;
   logic [DATA_W-1:0]   Hwdata1;
   logic [DATA_W-1:0]   Hwdata2;
   logic                Hwritereg;
   logic                Hwritereg1;
   logic [NUM_SLV-1:0]  tempselx;
   logic                valid;
   logic                Hreadyout;
   logic [1:0]          Hresp;
   logic [DATA_W-1:0]   Hrdata;
   logic [ERRCNT_W-1:0] err_count;

   modport slave (
      input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, prdata, apb_ready,
      output Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
             tempselx, valid, Hreadyout, Hresp, Hrdata, err_count
   );

   modport master (
      output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, prdata, apb_ready,
      input  Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
             tempselx, valid, Hreadyout, Hresp, Hrdata, err_count
   );
endinterface

// File: rtl/ahb_addr_decoder.sv
// One-hot decode of NUM_SLV equal, contiguous, half-open address regions.
// Bounds are computed with headroom bits so the last region end never wraps.
module ahb_addr_decoder #(
   parameter int                ADDR_W    = 32,
   parameter int                NUM_SLV   = 3,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] REGION_SZ = 32'h0400_0000
) (
   input  logic [ADDR_W-1:0]  i_addr,
   output logic [NUM_SLV-1:0] o_sel,
   output logic               o_mapped
);
   localparam int CW = ADDR_W + $clog2(NUM_SLV) + 1;

   logic [CW-1:0] w_addr;

   assign w_addr = CW'(i_addr);

   for (genvar g = 0; g < NUM_SLV; g++) begin : g_rgn
      localparam logic [CW-1:0] LO = CW'(BASE_ADDR) + CW'(g) * CW'(REGION_SZ);
      localparam logic [CW-1:0] HI = LO + CW'(REGION_SZ);
      assign o_sel[g] = (w_addr >= LO) && (w_addr < HI);
   end

   assign o_mapped = |o_sel;

endmodule

// File: rtl/ahb_slave_if_param.sv
// AHB front end of the AHB-APB bridge: address/data/write pipeline, region
// decode, two-cycle ERROR response for unmapped transfers, saturating error count.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   OKAY_ST | normal operation, Hresp OKAY, Hreadyout follows apb_ready
//   ERR1    | first ERROR cycle, wait state (Hreadyout=0), counts error
//   ERR2    | second ERROR cycle, Hreadyout=1 completes the response
module ahb_slave_if_param
   import ahb_apb_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                NUM_SLV   = 3,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] REGION_SZ = 32'h0400_0000,
   parameter int                ERRCNT_W  = 8
) (
   input  logic                 Hclk,
   input  logic                 Hresetn,
   ahb_slave_if_param_if.slave  bus
);
   err_state_e          r_state;
   err_state_e          w_next_state;
   logic [ADDR_W-1:0]   r_haddr1, r_haddr2;
   logic [DATA_W-1:0]   r_hwdata1, r_hwdata2;
   logic                r_hwrite1, r_hwrite2;
   logic [ERRCNT_W-1:0] r_err_count;
   logic [NUM_SLV-1:0]  w_tempselx;
   logic                w_mapped;
   logic                w_active;
   logic                w_hreadyout;
   logic [1:0]          w_hresp;

   ahb_addr_decoder #(
      .ADDR_W   (ADDR_W),
      .NUM_SLV  (NUM_SLV),
      .BASE_ADDR(BASE_ADDR),
      .REGION_SZ(REGION_SZ)
   ) u_dec (
      .i_addr  (bus.Haddr),
      .o_sel   (w_tempselx),
      .o_mapped(w_mapped)
   );

   assign w_active = bus.Hreadyin & bus.Htrans[1];

   // Pipeline stages advance only when the bus is not stalled.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_haddr1  <= '0;
         r_haddr2  <= '0;
         r_hwdata1 <= '0;
         r_hwdata2 <= '0;
         r_hwrite1 <= 1'b0;
         r_hwrite2 <= 1'b0;
      end else if (bus.Hreadyin) begin
         r_haddr1  <= bus.Haddr;
         r_haddr2  <= r_haddr1;
         r_hwdata1 <= bus.Hwdata;
         r_hwdata2 <= r_hwdata1;
         r_hwrite1 <= bus.Hwrite;
         r_hwrite2 <= r_hwrite1;
      end
   end

   // Error-response state register.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) r_state <= OKAY_ST;
      else          r_state <= w_next_state;
   end

   // Next state and response outputs; unmapped transfers during ERR1/ERR2 are ignored.
   always_comb begin
      w_next_state = r_state;
      w_hresp      = HRESP_OKAY;
      w_hreadyout  = bus.apb_ready;
      case (r_state)
         OKAY_ST: if (w_active && !w_mapped) w_next_state = ERR1;
         ERR1: begin
            w_hresp      = HRESP_ERROR;
            w_hreadyout  = 1'b0;
            w_next_state = ERR2;
         end
         ERR2: begin
            w_hresp      = HRESP_ERROR;
            w_hreadyout  = 1'b1;
            w_next_state = OKAY_ST;
         end
         default: w_next_state = OKAY_ST;
      endcase
   end

   // One count per error response, taken on leaving ERR1; sticks at all-ones.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn)
         r_err_count <= '0;
      else if (r_state == ERR1 && r_err_count != '1)
         r_err_count <= r_err_count + ERRCNT_W'(1);
   end

   assign bus.Haddr1     = r_haddr1;
   assign bus.Haddr2     = r_haddr2;
   assign bus.Hwdata1    = r_hwdata1;
   assign bus.Hwdata2    = r_hwdata2;
   assign bus.Hwritereg  = r_hwrite1;
   assign bus.Hwritereg1 = r_hwrite2;
   assign bus.tempselx   = w_tempselx;
   assign bus.valid      = w_active & w_mapped & (r_state == OKAY_ST);
   assign bus.Hreadyout  = w_hreadyout;
   assign bus.Hresp      = w_hresp;
   assign bus.Hrdata     = bus.prdata;
   assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Bench for ahb_slave_if_param: directed stimulus pushes expected values into a
// queue tagged with the cycle they apply to; a monitor pops and compares at negedge.
module tb_ahb_slave_if_param;
   import ahb_apb_pkg::*;

   localparam int S_SEL = 0, S_VLD = 1, S_RDY = 2, S_RSP = 3, S_A1 = 4, S_A2 = 5,
                  S_D1 = 6, S_D2 = 7, S_EC = 8, S_W1 = 9, S_W2 = 10, S_RD = 11, S_EC2 = 12;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        t_hresetn;
   logic        t_hwrite, t_hreadyin, t_apb_ready;
   logic [1:0]  t_htrans;
   logic [31:0] t_haddr, t_hwdata, t_prdata;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   exp_t        q[$];

   ahb_slave_if_param_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .ERRCNT_W(8)) b1 ();
   ahb_slave_if_param_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .ERRCNT_W(2)) b2 ();

   assign b1.Hwrite = t_hwrite;     assign b2.Hwrite = t_hwrite;
   assign b1.Hreadyin = t_hreadyin; assign b2.Hreadyin = t_hreadyin;
   assign b1.Htrans = t_htrans;     assign b2.Htrans = t_htrans;
   assign b1.Haddr = t_haddr;       assign b2.Haddr = t_haddr;
   assign b1.Hwdata = t_hwdata;     assign b2.Hwdata = t_hwdata;
   assign b1.prdata = t_prdata;     assign b2.prdata = t_prdata;
   assign b1.apb_ready = t_apb_ready; assign b2.apb_ready = t_apb_ready;

   ahb_slave_if_param #(
      .ADDR_W(32), .DATA_W(32), .NUM_SLV(3),
      .BASE_ADDR(32'h8000_0000), .REGION_SZ(32'h0400_0000), .ERRCNT_W(8)
   ) u_dut1 (.Hclk(clk), .Hresetn(t_hresetn), .bus(b1.slave));

   ahb_slave_if_param #(
      .ADDR_W(32), .DATA_W(32), .NUM_SLV(3),
      .BASE_ADDR(32'h8000_0000), .REGION_SZ(32'h0400_0000), .ERRCNT_W(2)
   ) u_dut2 (.Hclk(clk), .Hresetn(t_hresetn), .bus(b2.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] act(int sel);
      case (sel)
         S_SEL:   return 32'(b1.tempselx);
         S_VLD:   return 32'(b1.valid);
         S_RDY:   return 32'(b1.Hreadyout);
         S_RSP:   return 32'(b1.Hresp);
         S_A1:    return b1.Haddr1;
         S_A2:    return b1.Haddr2;
         S_D1:    return b1.Hwdata1;
         S_D2:    return b1.Hwdata2;
         S_EC:    return 32'(b1.err_count);
         S_W1:    return 32'(b1.Hwritereg);
         S_W2:    return 32'(b1.Hwritereg1);
         S_RD:    return b1.Hrdata;
         S_EC2:   return 32'(b2.err_count);
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   // Scoreboard monitor.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] a;
         e = q.pop_front();
         a = act(e.sel);
         n_checks++;
         if (e.cyc != cyc)
            $display("FAIL %s stale (queued cyc %0d, now %0d)", e.name, e.cyc, cyc);
         else if (a === e.val)
            n_pass++;
         else
            $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, a, e.val);
      end
   end

   task automatic ex(string name, int sel, logic [31:0] val);
      exp_t e;
      e.cyc = cyc; e.sel = sel; e.val = val; e.name = name;
      q.push_back(e);
   endtask

   task automatic drive(logic [1:0] tr, logic [31:0] a, logic [31:0] d, logic w, logic rdy);
      @(posedge clk);
      #1;
      t_htrans = tr; t_haddr = a; t_hwdata = d; t_hwrite = w; t_hreadyin = rdy;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      t_hresetn = 1'b0; t_hwrite = 1'b0; t_hreadyin = 1'b1; t_apb_ready = 1'b1;
      t_htrans = HTRANS_IDLE; t_haddr = '0; t_hwdata = '0; t_prdata = '0;

      // reset state
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("rst_a1", S_A1, 0); ex("rst_a2", S_A2, 0); ex("rst_ec", S_EC, 0);
      ex("rst_rsp", S_RSP, 0); ex("rst_rdy", S_RDY, 1); ex("rst_vld", S_VLD, 0);
      ex("rst_sel", S_SEL, 0);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      t_hresetn = 1'b1;

      // pipeline of a single NONSEQ write
      drive(HTRANS_NONSEQ, 32'h8000_0010, 32'hA5A5_A5A5, 1, 1);
      ex("wr_sel", S_SEL, 3'b001); ex("wr_vld", S_VLD, 1);
      ex("wr_rsp", S_RSP, HRESP_OKAY); ex("wr_rdy", S_RDY, 1);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("p1_a1", S_A1, 32'h8000_0010); ex("p1_d1", S_D1, 32'hA5A5_A5A5);
      ex("p1_w1", S_W1, 1); ex("p1_vld", S_VLD, 0); ex("p1_sel", S_SEL, 0);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("p2_a2", S_A2, 32'h8000_0010); ex("p2_d2", S_D2, 32'hA5A5_A5A5);
      ex("p2_w2", S_W2, 1); ex("p2_a1", S_A1, 0); ex("p2_w1", S_W1, 0);

      // region boundaries
      drive(HTRANS_NONSEQ, 32'h8400_0000, 0, 0, 1);
      ex("b_8400", S_SEL, 3'b010); ex("b_8400_v", S_VLD, 1);
      drive(HTRANS_SEQ, 32'h83FF_FFFC, 0, 0, 1);
      ex("b_83ff", S_SEL, 3'b001); ex("b_83ff_v", S_VLD, 1);
      drive(HTRANS_SEQ, 32'h8800_0000, 0, 0, 1);
      ex("b_8800", S_SEL, 3'b100);
      drive(HTRANS_SEQ, 32'h8BFF_FFFC, 0, 0, 1);
      ex("b_8bff", S_SEL, 3'b100);
      drive(HTRANS_IDLE, 32'h8C00_0000, 0, 0, 1);
      ex("b_8c00", S_SEL, 3'b000); ex("b_8c00_v", S_VLD, 0);
      drive(HTRANS_IDLE, 32'h7FFF_FFFC, 0, 0, 1);
      ex("b_7fff", S_SEL, 3'b000); ex("idle_unm_rsp", S_RSP, HRESP_OKAY);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("idle_unm_rsp2", S_RSP, HRESP_OKAY);

      // stall holds all stages
      drive(HTRANS_NONSEQ, 32'h8000_1000, 32'h1111_1111, 1, 1);
      drive(HTRANS_NONSEQ, 32'h8000_2000, 32'h2222_2222, 0, 1);
      for (int k = 0; k < 3; k++) begin
         drive(HTRANS_NONSEQ, (k == 2) ? 32'h9000_0000 : 32'h8000_3000 + 32'(k) * 32'h1000,
               32'h3333_3333 + 32'(k), 1, 0);
         ex("st_a1", S_A1, 32'h8000_2000); ex("st_a2", S_A2, 32'h8000_1000);
         ex("st_d1", S_D1, 32'h2222_2222); ex("st_d2", S_D2, 32'h1111_1111);
         ex("st_vld", S_VLD, 0);
      end
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("st_a1_end", S_A1, 32'h8000_2000); ex("st_w1", S_W1, 0); ex("st_w2", S_W2, 1);
      ex("st_rsp", S_RSP, HRESP_OKAY);

      // apb_ready passthrough and read data
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      t_apb_ready = 1'b0; t_prdata = 32'hDEAD_BEEF;
      ex("apb_nrdy", S_RDY, 0); ex("hrdata", S_RD, 32'hDEAD_BEEF);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      t_apb_ready = 1'b1; t_prdata = 32'h0123_4567;
      ex("apb_rdy", S_RDY, 1); ex("hrdata2", S_RD, 32'h0123_4567);

      // first error response
      drive(HTRANS_NONSEQ, 32'h9000_0000, 0, 0, 1);
      ex("e0_sel", S_SEL, 0); ex("e0_vld", S_VLD, 0);
      ex("e0_rsp", S_RSP, HRESP_OKAY); ex("e0_rdy", S_RDY, 1);
      drive(HTRANS_NONSEQ, 32'h9000_0004, 0, 0, 1);
      ex("e1_rsp", S_RSP, HRESP_ERROR); ex("e1_rdy", S_RDY, 0); ex("e1_ec", S_EC, 0);
      ex("e1_vld", S_VLD, 0);
      drive(HTRANS_NONSEQ, 32'h8000_0000, 0, 0, 1);
      ex("e2_rsp", S_RSP, HRESP_ERROR); ex("e2_rdy", S_RDY, 1); ex("e2_ec", S_EC, 1);
      ex("e2_vld", S_VLD, 0); ex("e2_sel", S_SEL, 3'b001); ex("e2_ec2", S_EC2, 1);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("e3_rsp", S_RSP, HRESP_OKAY); ex("e3_rdy", S_RDY, 1); ex("e3_ec", S_EC, 1);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("e4_rsp", S_RSP, HRESP_OKAY); ex("e4_ec", S_EC, 1);

      // back-to-back unmapped: one error per 3 cycles, narrow counter saturates
      for (int k = 0; k < 4; k++) begin
         drive(HTRANS_NONSEQ, 32'hA000_0000, 0, 0, 1);
         ex("bb_ok_rsp", S_RSP, HRESP_OKAY);
         drive(HTRANS_NONSEQ, 32'hA000_0000, 0, 0, 1);
         ex("bb_e1_rsp", S_RSP, HRESP_ERROR);
         drive(HTRANS_NONSEQ, 32'hA000_0000, 0, 0, 1);
         ex("bb_e2_rsp", S_RSP, HRESP_ERROR);
         ex("bb_ec", S_EC, 32'(2 + k));
         ex("bb_ec2", S_EC2, (2 + k > 3) ? 32'd3 : 32'(2 + k));
      end
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("sat_rsp", S_RSP, HRESP_OKAY); ex("sat_ec", S_EC, 5); ex("sat_ec2", S_EC2, 3);

      // BUSY to unmapped address raises nothing
      drive(HTRANS_BUSY, 32'h9000_0000, 0, 0, 1);
      ex("busy_vld", S_VLD, 0); ex("busy_sel", S_SEL, 0);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("busy_rsp", S_RSP, HRESP_OKAY); ex("busy_rdy", S_RDY, 1);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      ex("busy_ec", S_EC, 5);

      // async reset in the middle of ERR1
      drive(HTRANS_NONSEQ, 32'h9000_0000, 32'h7777_7777, 1, 1);
      drive(HTRANS_IDLE, 32'h8000_0020, 0, 0, 1);
      t_hresetn = 1'b0;
      ex("mr_rsp", S_RSP, HRESP_OKAY); ex("mr_rdy", S_RDY, 1); ex("mr_ec", S_EC, 0);
      ex("mr_ec2", S_EC2, 0); ex("mr_a1", S_A1, 0); ex("mr_d1", S_D1, 0);
      ex("mr_w1", S_W1, 0);
      drive(HTRANS_IDLE, 0, 0, 0, 1);
      t_hresetn = 1'b1;
      drive(HTRANS_NONSEQ, 32'h8000_0000, 0, 0, 1);
      ex("post_rsp", S_RSP, HRESP_OKAY); ex("post_vld", S_VLD, 1); ex("post_ec", S_EC, 0);

      @(negedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain left=%0d required=0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
